// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - shared types and default widths for the reorder buffer
package rob_pkg;

    localparam int ROB_DEPTH      = 64;
    localparam int ROB_PREG_W     = 6;
    localparam int ROB_XLEN       = 32;
    localparam int ROB_CMPL_PORTS = 3;
    localparam int ROB_RETIRE_W   = 2;

    typedef struct packed {
        logic                  valid;
        logic                  done;
        logic                  has_dest;
        logic [ROB_PREG_W-1:0] dr;
        logic [ROB_PREG_W-1:0] old_dr;
        logic [ROB_XLEN-1:0]   pc;
        logic [ROB_XLEN-1:0]   data;
    } rob_entry_t;

endpackage

// File: rtl/rob_retire_sel.sv
// rtl/rob_retire_sel.sv - in-order retire prefix selector over the head window
module rob_retire_sel #(
    parameter int RETIRE_W = 2,
    parameter int CNT_W    = 7,
    parameter int N_W      = 2
) (
    input  logic [RETIRE_W-1:0] rdy,
    input  logic [CNT_W-1:0]    count,
    output logic [RETIRE_W-1:0] mask,
    output logic [N_W-1:0]      n
);

    logic alive;

    // The first slot that is not ready, or lies at/after the tail, ends the prefix.
    always_comb begin
        mask  = '0;
        n     = '0;
        alive = 1'b1;
        for (int s = 0; s < RETIRE_W; s++) begin
            if (alive && rdy[s] && (CNT_W'(s) < count)) begin
                mask[s] = 1'b1;
                n       = n + 1'b1;
            end else begin
                alive = 1'b0;
            end
        end
    end

endmodule

// File: rtl/rob_ring.sv
// rtl/rob_ring.sv - circular reorder buffer with in-order retire and wakeup forwarding
module rob_ring
    import rob_pkg::*;
#(
    parameter int DEPTH      = ROB_DEPTH,
    parameter int IDX_W      = $clog2(DEPTH),
    parameter int PREG_W     = ROB_PREG_W,
    parameter int XLEN       = ROB_XLEN,
    parameter int CMPL_PORTS = ROB_CMPL_PORTS,
    parameter int RETIRE_W   = ROB_RETIRE_W
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         flush,
    input  logic                         disp_valid,
    input  logic                         disp_has_dest,
    input  logic [PREG_W-1:0]            disp_dr,
    input  logic [PREG_W-1:0]            disp_old_dr,
    input  logic [XLEN-1:0]              disp_pc,
    output logic                         disp_ready,
    output logic [IDX_W-1:0]             disp_idx,
    input  logic [CMPL_PORTS-1:0]        cmpl_valid,
    input  logic [CMPL_PORTS*IDX_W-1:0]  cmpl_idx,
    input  logic [CMPL_PORTS*XLEN-1:0]   cmpl_data,
    output logic [CMPL_PORTS-1:0]        wb_valid,
    output logic [CMPL_PORTS*PREG_W-1:0] wb_preg,
    output logic [CMPL_PORTS*XLEN-1:0]   wb_data,
    output logic [RETIRE_W-1:0]          ret_valid,
    output logic [RETIRE_W-1:0]          ret_has_dest,
    output logic [RETIRE_W*PREG_W-1:0]   ret_dr,
    output logic [RETIRE_W*PREG_W-1:0]   ret_old_dr,
    output logic [RETIRE_W*XLEN-1:0]     ret_data,
    output logic [RETIRE_W*XLEN-1:0]     ret_pc,
    output logic [IDX_W:0]               count
);

    localparam int CNT_W = IDX_W + 1;
    localparam int N_W   = $clog2(RETIRE_W + 1);

    rob_entry_t        mem [DEPTH];
    logic [IDX_W-1:0]  head_q;
    logic [IDX_W-1:0]  tail_q;
    logic [CNT_W-1:0]  count_q;

    logic              full;
    logic              disp_fire;

    logic [IDX_W-1:0]      ret_slot_idx [RETIRE_W];
    logic [RETIRE_W-1:0]   ret_rdy;
    logic [RETIRE_W-1:0]   ret_mask;
    logic [N_W-1:0]        ret_n;

    logic [IDX_W-1:0]      c_idx [CMPL_PORTS];
    logic [CMPL_PORTS-1:0] c_acc;
    logic [CMPL_PORTS-1:0] c_wake;

    // Admission looks only at the registered count, so a same-cycle retire never frees a slot.
    assign full       = (count_q == CNT_W'(DEPTH));
    assign disp_ready = !full;
    assign disp_idx   = tail_q;
    assign disp_fire  = disp_valid && !full;
    assign count      = count_q;

    always_comb begin
        for (int s = 0; s < RETIRE_W; s++) begin
            ret_slot_idx[s] = head_q + IDX_W'(s);
            ret_rdy[s]      = mem[ret_slot_idx[s]].valid && mem[ret_slot_idx[s]].done;
        end
    end

    rob_retire_sel #(
        .RETIRE_W (RETIRE_W),
        .CNT_W    (CNT_W),
        .N_W      (N_W)
    ) u_retire_sel (
        .rdy   (ret_rdy),
        .count (count_q),
        .mask  (ret_mask),
        .n     (ret_n)
    );

    for (genvar p = 0; p < CMPL_PORTS; p++) begin : g_cidx
        assign c_idx[p] = cmpl_idx[p*IDX_W +: IDX_W];
    end

    // A port loses to any lower-numbered port strobing the same index this cycle.
    always_comb begin
        c_acc  = '0;
        c_wake = '0;
        for (int p = 0; p < CMPL_PORTS; p++) begin
            c_acc[p] = cmpl_valid[p] && mem[c_idx[p]].valid && !mem[c_idx[p]].done;
            for (int q = 0; q < p; q++) begin
                if (cmpl_valid[q] && (c_idx[q] == c_idx[p])) begin
                    c_acc[p] = 1'b0;
                end
            end
            c_wake[p] = c_acc[p] && mem[c_idx[p]].has_dest;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i].valid <= 1'b0;
                mem[i].done  <= 1'b0;
            end
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i].valid <= 1'b0;
                mem[i].done  <= 1'b0;
            end
        end else begin
            for (int s = 0; s < RETIRE_W; s++) begin
                if (ret_mask[s]) begin
                    mem[ret_slot_idx[s]].valid <= 1'b0;
                    mem[ret_slot_idx[s]].done  <= 1'b0;
                end
            end
            for (int p = 0; p < CMPL_PORTS; p++) begin
                if (c_acc[p]) begin
                    mem[c_idx[p]].done <= 1'b1;
                    mem[c_idx[p]].data <= cmpl_data[p*XLEN +: XLEN];
                end
            end
            if (disp_fire) begin
                mem[tail_q] <= '{valid:    1'b1,
                                 done:     1'b0,
                                 has_dest: disp_has_dest,
                                 dr:       disp_dr,
                                 old_dr:   disp_old_dr,
                                 pc:       disp_pc,
                                 data:     '0};
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (disp_fire) begin
                tail_q <= tail_q + 1'b1;
            end
            head_q  <= head_q + IDX_W'(ret_n);
            count_q <= count_q + CNT_W'(disp_fire) - CNT_W'(ret_n);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ret_valid    <= '0;
            ret_has_dest <= '0;
            ret_dr       <= '0;
            ret_old_dr   <= '0;
            ret_data     <= '0;
            ret_pc       <= '0;
            wb_valid     <= '0;
            wb_preg      <= '0;
            wb_data      <= '0;
        end else if (flush) begin
            ret_valid    <= '0;
            ret_has_dest <= '0;
            ret_dr       <= '0;
            ret_old_dr   <= '0;
            ret_data     <= '0;
            ret_pc       <= '0;
            wb_valid     <= '0;
            wb_preg      <= '0;
            wb_data      <= '0;
        end else begin
            for (int s = 0; s < RETIRE_W; s++) begin
                ret_valid[s]    <= ret_mask[s];
                ret_has_dest[s] <= ret_mask[s] && mem[ret_slot_idx[s]].has_dest;
                ret_dr[s*PREG_W +: PREG_W]     <= ret_mask[s] ? mem[ret_slot_idx[s]].dr     : '0;
                ret_old_dr[s*PREG_W +: PREG_W] <= ret_mask[s] ? mem[ret_slot_idx[s]].old_dr : '0;
                ret_data[s*XLEN +: XLEN]       <= ret_mask[s] ? mem[ret_slot_idx[s]].data   : '0;
                ret_pc[s*XLEN +: XLEN]         <= ret_mask[s] ? mem[ret_slot_idx[s]].pc     : '0;
            end
            for (int p = 0; p < CMPL_PORTS; p++) begin
                wb_valid[p]                <= c_wake[p];
                wb_preg[p*PREG_W +: PREG_W] <= c_wake[p] ? mem[c_idx[p]].dr : '0;
                wb_data[p*XLEN +: XLEN]     <= c_wake[p] ? cmpl_data[p*XLEN +: XLEN] : '0;
            end
        end
    end

endmodule

// File: doc/rob_ring.md
Name: rob_ring

Overview:
- Parametrised circular reorder buffer; successor to the first-generation ROB.
- Sits between rename/dispatch and the ARF/free list. Dispatch allocates entries in order at the tail. Functional units mark entries complete by ROB index (not PC). Completed entries at the head retire in program order, up to RETIRE_W per cycle.
- Adds a precise full/stall indication, occupancy count, registered wakeup forwarding to the issue queue, and a synchronous flush.

Parameters:
- DEPTH, 64, number of entries; must be a power of 2, at least 4
- IDX_W, $clog2(DEPTH), ROB index width
- PREG_W, 6, physical register tag width
- XLEN, 32, data and PC width
- CMPL_PORTS, 3, number of completion/wakeup ports
- RETIRE_W, 2, maximum retirements per cycle

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous squash of all entries
- disp_valid  in  1  dispatch request
- disp_has_dest  in  1  instruction writes a register (0 for store/branch)
- disp_dr  in  PREG_W  new physical destination
- disp_old_dr  in  PREG_W  previous mapping of the architectural destination
- disp_pc  in  XLEN  instruction PC
- disp_ready  out  1  equals !full; rename stalls when low
- disp_idx  out  IDX_W  tail index allocated to this dispatch (combinational)
- cmpl_valid  in  CMPL_PORTS  per-port completion strobe
- cmpl_idx  in  CMPL_PORTS*IDX_W  ROB index per port
- cmpl_data  in  CMPL_PORTS*XLEN  result per port
- wb_valid  out  CMPL_PORTS  registered wakeup strobe to the issue queue
- wb_preg  out  CMPL_PORTS*PREG_W  woken physical register
- wb_data  out  CMPL_PORTS*XLEN  forwarded value
- ret_valid  out  RETIRE_W  retire strobe per slot; valid slots are a contiguous prefix from slot 0
- ret_has_dest  out  RETIRE_W  per-slot has-destination flag
- ret_dr / ret_old_dr  out  RETIRE_W*PREG_W  ARF target / tag to free
- ret_data / ret_pc  out  RETIRE_W*XLEN  retired value / PC
- count  out  IDX_W+1  current occupancy

Behaviour:
- Reset (async): all valid/done bits cleared; head=tail=count=0; all ret_*, wb_*, and count outputs are 0; disp_ready=1.
- Storage per entry: valid, done, has_dest, dr, old_dr, pc, data. Pointers are IDX_W bits and wrap modulo DEPTH. full = (count==DEPTH); empty = (count==0).
- Dispatch: on a posedge with disp_valid && disp_ready, write the entry at tail with valid=1 and done=0, then tail++. disp_valid while full is ignored (no write, no pointer move). disp_ready reflects registered count only; a retire in the same cycle does not admit a dispatch into a full ROB.
- Complete: for each port p with cmpl_valid[p] whose target entry is valid and not done, set done=1 and data=cmpl_data[p] at the posedge. Completion to an invalid or already-done entry is ignored. Duplicate indices across ports in one cycle: the lowest port wins.
- Wakeup: one cycle after an accepted completion, wb_valid[p]=1, wb_preg[p]=dr of that entry, wb_data[p]=data. wb_valid[p]=0 when the entry has has_dest=0 or the completion was ignored.
- Retire: each posedge, evaluate entries head..head+RETIRE_W-1 using state at the start of the cycle. Retire the longest prefix with valid && done, never passing tail. For each retired slot: drive ret_* registered (visible the cycle after), clear valid/done, advance head by the retired count. An entry completing in cycle N is retireable no earlier than cycle N+1, with ret_valid in cycle N+2. ret_valid deasserts in cycles with no retirement.
- Count: count_next = count + dispatched - retired. Simultaneous dispatch and retire are both legal when not full.
- Flush: at the posedge, clear all valid/done bits, set head=tail=count=0, and force ret_valid=0 and wb_valid=0 next cycle. Flush overrides dispatch, complete, and retire in the same cycle.
- Reset mid-operation: immediate async clear; no partial retirement is emitted.

Decomposition:
- Package rob_pkg: entry struct (valid, done, has_dest, dr, old_dr, pc, data); localparams for default widths.
- Sub-module rob_retire_sel: combinational prefix selector taking RETIRE_W valid&done bits and head/count, returning the retire mask and count.

Test Plan:
- Reset, then dispatch 3 entries (pc 0x0, 0x4, 0x8; dr 10, 11, 12) → disp_idx 0, 1, 2; count=3.
- Complete idx 1 (data 0xBB), then idx 0 (data 0xAA) → no retire after the first; after the second, ret_valid=2'b11 with ret_pc 0x0/0x4 and ret_data 0xAA/0xBB in order; wb_preg 11 then 10.
- Fill 64 entries → disp_ready=0; a 65th disp_valid is ignored; retire 2 → count=62, disp_ready=1 the next cycle.
- Wrap: with head=62, dispatch 4 → indices 62, 63, 0, 1; complete all → retirement in order 62, 63, 0, 1 across two cycles.
- Three ports complete idx 3, 4, 5 in the same cycle → wb_valid=3'b111 the next cycle with the correct preg/data; a completion to an invalid idx gives wb_valid=0 on that port.
- Flush with 10 entries, one completing the same cycle → count=0, no ret_valid or wb_valid afterwards; the next dispatch gets idx 0.
